// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between I-fetch refills and D-cache refills/writes.
// Define ARB_ROUND_ROBIN_EN to alternate the winner on contention; default gives D fixed priority.
module mem_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  localparam int BW        = LINE_WORDS > 1 ? $clog2(LINE_WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic              d_done,
  output logic [DATA_W-1:0] rdata,
  output logic [BW-1:0]     beat_idx,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int OFF = $clog2(LINE_WORDS * 4);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'((64'd1 << OFF) - 64'd1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t r_state, w_next;
  logic r_own_d, r_we, r_i_gnt, r_d_gnt;
  logic [ADDR_W-1:0] r_base, w_base;
  logic [DATA_W-1:0] r_wdata;
  logic [BW-1:0] r_beat;
  logic w_take, w_take_d, w_last, w_acc;
`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_d;
  assign w_take_d = d_req & (!i_req | !r_last_d);
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_last_d <= 1'b1;
    else if (r_state == IDLE && w_take) r_last_d <= w_take_d;
`else
  assign w_take_d = d_req;
`endif
  assign w_take   = i_req | d_req;
  // writes are word-aligned, reads are aligned to the start of the line
  assign w_base   = (w_take_d & d_we) ? {d_addr[ADDR_W-1:2], 2'b00}
                                      : ((w_take_d ? d_addr : i_addr) & ~LINE_MASK);
  assign w_last   = r_we | (r_beat == BW'(LINE_WORDS - 1));
  assign w_acc    = (r_state == BUSY) & mem_ready;
  assign i_gnt    = r_i_gnt;
  assign d_gnt    = r_d_gnt;
  assign beat_idx = r_beat;
  assign busy     = r_state != IDLE;
  always_comb begin
    w_next    = r_state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rdata     = '0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    case (r_state)
      IDLE: w_next = w_take ? BUSY : IDLE;
      BUSY: begin
        mem_req   = 1'b1;
        mem_we    = r_we;
        mem_addr  = r_base + (ADDR_W'(r_beat) << 2);
        mem_wdata = r_wdata;
        if (mem_ready) begin
          w_next   = w_last ? DONE : BUSY;
          i_rvalid = !r_we & !r_own_d;
          d_rvalid = !r_we & r_own_d;
          rdata    = r_we ? '0 : mem_rdata;
        end
      end
      DONE: begin
        w_next = IDLE;
        i_done = !r_own_d;
        d_done = r_own_d;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= IDLE;
      r_own_d <= 1'b1;
      r_we    <= 1'b0;
      r_base  <= '0;
      r_wdata <= '0;
      r_beat  <= '0;
      r_i_gnt <= 1'b0;
      r_d_gnt <= 1'b0;
    end else begin
      r_state <= w_next;
      r_i_gnt <= (r_state == IDLE) & w_take & !w_take_d;
      r_d_gnt <= (r_state == IDLE) & w_take_d;
      if (r_state == IDLE && w_take) begin
        r_own_d <= w_take_d;
        r_we    <= w_take_d & d_we;
        r_wdata <= d_wdata;
        r_base  <= w_base;
      end
      r_beat <= r_state == DONE ? '0 : (w_acc ? r_beat + BW'(1) : r_beat);
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter with a transaction-level reference model.
module tb_mem_arbiter;
  localparam int LW = 4;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 0, rst = 0;
  logic i_req = 0, d_req = 0, d_we = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0;
  logic i_gnt, i_rvalid, i_done, d_gnt, d_rvalid, d_done, busy, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0] beat_idx;
  logic mem_ready = 1;
  always #5 clk = ~clk;

  mem_arbiter #(.LINE_WORDS(LW), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_done(d_done),
    .rdata(rdata), .beat_idx(beat_idx), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  typedef struct {logic [31:0] a; logic we; logic [31:0] wd;} acc_t;
  typedef struct {logic d; logic [31:0] data; int idx;} beat_t;
  logic  q_gnt[$];
  logic  q_done[$];
  acc_t  q_acc[$];
  beat_t q_beat[$];
  int total = 0, bad = 0, stalls = 0, ready_mode = 0;
  logic last_d = 1, script_ready = 1;

  function automatic logic [31:0] mf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00A0_00A0;
  endfunction
  assign mem_rdata = mf(mem_addr);

  always @(posedge clk) begin
    #1;
    mem_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? ($urandom_range(0, 2) != 0) : script_ready;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm, input logic [63:0] v);
    total++;
    bad++;
    $display("FAIL %s: got %0h with nothing expected", nm, v);
  endtask

  // expected events for one whole transfer, derived from addresses alone
  task automatic push_txn(input logic d, input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input int nbeats, input bit with_done);
    logic [31:0] base, ad;
    int n;
    q_gnt.push_back(d);
    n = we ? 1 : LW;
    base = we ? a - (a % 4) : a - (a % (LW * 4));
    for (int k = 0; k < n && k < nbeats; k++) begin
      ad = base + 32'(4 * k);
      q_acc.push_back('{ad, we, wd});
      if (!we) q_beat.push_back('{d, mf(ad), k});
    end
    if (with_done) q_done.push_back(d);
  endtask

  task automatic predict(input bit ri, input bit rd, input logic [31:0] ia, input logic [31:0] da,
                         input bit dwe, input logic [31:0] dwd);
    logic first_d;
    if (ri && rd) begin
      first_d = RR ? !last_d : 1'b1;
      if (first_d) begin
        push_txn(1, dwe, da, dwd, LW, 1); push_txn(0, 0, ia, 0, LW, 1); last_d = 0;
      end else begin
        push_txn(0, 0, ia, 0, LW, 1); push_txn(1, dwe, da, dwd, LW, 1); last_d = 1;
      end
    end else if (rd) begin
      push_txn(1, dwe, da, dwd, LW, 1); last_d = 1;
    end else if (ri) begin
      push_txn(0, 0, ia, 0, LW, 1); last_d = 0;
    end
  endtask

  // requester behaviour: hold req until done, drop it the cycle after
  task automatic serve(input bit pi_in, input bit pd_in);
    bit pi, pd, si, sd;
    int cnt;
    pi = pi_in; pd = pd_in; cnt = 0;
    while ((pi || pd) && cnt < 500) begin
      @(negedge clk);
      si = i_done; sd = d_done;
      @(posedge clk); #1;
      if (si) begin i_req = 0; pi = 0; end
      if (sd) begin d_req = 0; pd = 0; end
      cnt++;
    end
    if (pi || pd) begin
      flag("done_timeout", {62'b0, pi, pd});
      i_req = 0; d_req = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input bit ri, input bit rd, input logic [31:0] ia, input logic [31:0] da,
                     input bit dwe, input logic [31:0] dwd);
    predict(ri, rd, ia, da, dwe, dwd);
    @(posedge clk); #1;
    i_addr = ia; d_addr = da; d_we = dwe; d_wdata = dwd; i_req = ri; d_req = rd;
    serve(ri, rd);
  endtask

  logic p_pend = 0, p_we = 0, m_e;
  logic [31:0] p_a = 0, p_wd = 0;
  acc_t m_a;
  beat_t m_b;
  always @(negedge clk) begin
    if (!rst) p_pend = 0;
    else begin
      if (p_pend) begin
        chk("hold_req", mem_req, 1);
        chk("hold_addr", mem_addr, p_a);
        chk("hold_we", mem_we, p_we);
        chk("hold_wdata", mem_wdata, p_wd);
      end
      if (mem_req && !mem_ready) stalls++;
      p_pend = mem_req && !mem_ready; p_a = mem_addr; p_we = mem_we; p_wd = mem_wdata;
      if (i_gnt || i_rvalid || i_done || d_gnt || d_rvalid || d_done)
        chk("exclusive", {i_gnt & d_gnt, i_rvalid & d_rvalid, i_done & d_done}, 0);
      if (i_gnt || d_gnt) begin
        if (q_gnt.size() == 0) flag("gnt_unexpected", {i_gnt, d_gnt});
        else begin m_e = q_gnt.pop_front(); chk("gnt_side", {i_gnt, d_gnt}, m_e ? 2'b01 : 2'b10); end
      end
      if (i_done || d_done) begin
        if (q_done.size() == 0) flag("done_unexpected", {i_done, d_done});
        else begin m_e = q_done.pop_front(); chk("done_side", {i_done, d_done}, m_e ? 2'b01 : 2'b10); end
      end
      if (mem_req && mem_ready) begin
        if (q_acc.size() == 0) flag("mem_unexpected", mem_addr);
        else begin
          m_a = q_acc.pop_front();
          chk("mem_addr", mem_addr, m_a.a);
          chk("mem_we", mem_we, m_a.we);
          if (m_a.we) chk("mem_wdata", mem_wdata, m_a.wd);
        end
      end
      if (i_rvalid || d_rvalid) begin
        if (q_beat.size() == 0) flag("beat_unexpected", rdata);
        else begin
          m_b = q_beat.pop_front();
          chk("beat_side", {i_rvalid, d_rvalid}, m_b.d ? 2'b01 : 2'b10);
          chk("beat_data", rdata, m_b.data);
          chk("beat_idx", beat_idx, m_b.idx);
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    int sel;
    i_req = 1; d_req = 1; i_addr = 32'h100; d_addr = 32'h204;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {i_gnt, i_rvalid, i_done, d_gnt, d_rvalid, d_done, busy, mem_req, mem_we, beat_idx}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    predict(1, 1, 32'h100, 32'h204, 0, 0);
    #1 rst = 1;
    @(negedge clk);
    chk("release_gnt", {i_gnt, d_gnt}, RR ? 2'b10 : 2'b01);
    serve(1, 1);
    run(1, 0, 32'h0000_1234, 0, 0, 0);
    run(0, 1, 0, 32'h0000_2006, 1, 32'hDEADBEEF);
    ready_mode = 2; script_ready = 1; stalls = 0;
    fork
      run(1, 0, 32'h0000_5558, 0, 0, 0);
      begin
        for (int c = 0; c < 100; c++) begin
          @(negedge clk);
          if (i_rvalid && beat_idx == 0) break;
        end
        script_ready = 0;
        repeat (3) @(negedge clk);
        script_ready = 1;
      end
    join
    chk("stall_cycles", stalls, 3);
    ready_mode = 1;
    run(1, 1, $urandom, $urandom, 0, 0);
    run(1, 1, $urandom, $urandom, 1, $urandom);
    ready_mode = 0;
    a = 32'h0000_3370;
    push_txn(0, 0, a, 0, 2, 0);
    @(posedge clk); #1;
    i_addr = a; i_req = 1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (i_rvalid && beat_idx == 1) break;
    end
    @(posedge clk); #3;
    rst = 0; i_req = 0; last_d = 1;
    @(negedge clk);
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", i_done, 0);
    chk("midrst_pending", q_gnt.size() + q_acc.size() + q_beat.size() + q_done.size(), 0);
    repeat (2) @(negedge clk);
    #1 rst = 1;
    run(1, 0, 32'h0000_3374, 0, 0, 0);
    ready_mode = 1;
    for (int t = 0; t < 30; t++) begin
      sel = $urandom_range(0, 2);
      run(sel != 1, sel != 0, $urandom, $urandom, $urandom_range(0, 1) == 1, $urandom);
    end
    repeat (5) @(negedge clk);
    chk("queues_drained", q_gnt.size() + q_acc.size() + q_beat.size() + q_done.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
